// File: rtl/spi_rx_deserializer.sv
// Passive SPI receive path: watches a master's CS/SCLK pins, rebuilds LSB-first
// words from the selected MISO line and queues them onto an AXI-Stream master.
module spi_rx_deserializer #(
    parameter int MAX_PACKAGE_SIZE = 8,
    parameter int SLAVE_COUNT      = 1,
    parameter int AXIS_TDATA_WIDTH = 32,
    parameter int FIFO_DEPTH       = 4
) (
    input  logic                                  aclk,
    input  logic                                  areset,
    input  logic                                  spi_clk,
    input  logic                                  cpol,
    input  logic                                  cpha,
    input  logic [$clog2(MAX_PACKAGE_SIZE+1)-1:0] package_size,
    input  logic [SLAVE_COUNT-1:0]                m_spi_cs_o,
    input  logic [SLAVE_COUNT-1:0]                m_spi_miso_i,
    output logic                                  m_axis_tvalid,
    output logic [AXIS_TDATA_WIDTH-1:0]           m_axis_tdata,
    input  logic                                  m_axis_tready,
    output logic                                  overflow,
    output logic                                  truncated,
    input  logic                                  clear_flags,
    output logic                                  busy
);

    localparam int PSW = $clog2(MAX_PACKAGE_SIZE + 1);
    localparam int PW  = $clog2(FIFO_DEPTH);
    localparam int CW  = $clog2(FIFO_DEPTH + 1);

    typedef enum logic {
        ST_IDLE,
        ST_CAPTURE
    } state_t;

    state_t                        state_reg, state_next;
    logic                          spi_clk_d;
    logic                          cs_active_d;
    logic [PSW-1:0]                n_reg, n_next;
    logic [SLAVE_COUNT-1:0]        sel_mask_reg, sel_mask_next;
    logic [PSW-1:0]                bit_cnt_reg, bit_cnt_next;
    logic [MAX_PACKAGE_SIZE-1:0]   shift_reg, shift_next, shift_upd;

    logic [AXIS_TDATA_WIDTH-1:0]   mem [FIFO_DEPTH];
    logic [PW-1:0]                 wr_ptr_reg, wr_ptr_next;
    logic [PW-1:0]                 rd_ptr_reg, rd_ptr_next;
    logic [CW-1:0]                 count_reg, count_next;
    logic                          tvalid_reg, tvalid_next;
    logic [AXIS_TDATA_WIDTH-1:0]   tdata_reg, tdata_next;
    logic                          overflow_reg, overflow_next;
    logic                          truncated_reg, truncated_next;

    logic                          sample_edge;
    logic                          cs_active;
    logic [SLAVE_COUNT-1:0]        sel_onehot;
    logic                          miso_sel;
    logic [PSW-1:0]                eff_size;
    logic                          push, push_ok, pop, full;
    logic                          trunc_set, ovf_set;
    logic [AXIS_TDATA_WIDTH-1:0]   push_word;

    // One-hot of the lowest-index chip-select that is low.
    genvar gi;
    generate
        for (gi = 0; gi < SLAVE_COUNT; gi++) begin : g_sel
            if (gi == 0) begin : g_first
                assign sel_onehot[gi] = ~m_spi_cs_o[gi];
            end else begin : g_rest
                assign sel_onehot[gi] = ~m_spi_cs_o[gi] & (&m_spi_cs_o[gi-1:0]);
            end
        end
    endgenerate

    assign cs_active   = ~(&m_spi_cs_o);
    assign miso_sel    = |(m_spi_miso_i & sel_mask_reg);
    assign sample_edge = (cpol ^ cpha) ? (~spi_clk & spi_clk_d) : (spi_clk & ~spi_clk_d);
    assign eff_size    = ((package_size == '0) || (package_size > PSW'(MAX_PACKAGE_SIZE)))
                         ? PSW'(MAX_PACKAGE_SIZE) : package_size;

    always_comb begin
        shift_upd = shift_reg;
        for (int i = 0; i < MAX_PACKAGE_SIZE; i++) begin
            if (bit_cnt_reg == PSW'(i)) shift_upd[i] = miso_sel;
        end
    end

    assign push_word = AXIS_TDATA_WIDTH'(shift_upd);

    always_comb begin
        state_next    = state_reg;
        n_next        = n_reg;
        sel_mask_next = sel_mask_reg;
        bit_cnt_next  = bit_cnt_reg;
        shift_next    = shift_reg;
        push          = 1'b0;
        trunc_set     = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (cs_active && !cs_active_d) begin
                    state_next    = ST_CAPTURE;
                    n_next        = eff_size;
                    sel_mask_next = sel_onehot;
                    bit_cnt_next  = '0;
                    shift_next    = '0;
                end
            end
            ST_CAPTURE: begin
                if (!cs_active) begin
                    state_next   = ST_IDLE;
                    trunc_set    = (bit_cnt_reg != '0);
                    bit_cnt_next = '0;
                    shift_next   = '0;
                end else if (sample_edge) begin
                    if (bit_cnt_reg == n_reg - PSW'(1)) begin
                        push         = 1'b1;
                        bit_cnt_next = '0;
                        shift_next   = '0;
                    end else begin
                        bit_cnt_next = bit_cnt_reg + PSW'(1);
                        shift_next   = shift_upd;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // A push at full is only accepted when the head leaves in the same cycle.
    always_comb begin
        pop         = tvalid_reg & m_axis_tready;
        full        = (count_reg == CW'(FIFO_DEPTH));
        push_ok     = push & (~full | pop);
        ovf_set     = push & full & ~pop;
        wr_ptr_next = push_ok ? wr_ptr_reg + PW'(1) : wr_ptr_reg;
        rd_ptr_next = pop ? rd_ptr_reg + PW'(1) : rd_ptr_reg;
        count_next  = count_reg + CW'(push_ok) - CW'(pop);
        tvalid_next = (count_next != '0);
        if (count_next == '0) begin
            tdata_next = tdata_reg;
        end else if (push_ok && (count_reg == CW'(pop))) begin
            tdata_next = push_word;
        end else begin
            tdata_next = mem[rd_ptr_next];
        end
        overflow_next  = clear_flags ? 1'b0 : overflow_reg;
        truncated_next = clear_flags ? 1'b0 : truncated_reg;
        if (ovf_set)   overflow_next  = 1'b1;
        if (trunc_set) truncated_next = 1'b1;
    end

    always_ff @(posedge aclk) begin
        if (push_ok) mem[wr_ptr_reg] <= push_word;
    end

    // cs_active_d resets high so a CS already low at release is not seen as a new frame.
    always_ff @(posedge aclk) begin
        if (areset) begin
            state_reg     <= ST_IDLE;
            spi_clk_d     <= 1'b0;
            cs_active_d   <= 1'b1;
            n_reg         <= PSW'(MAX_PACKAGE_SIZE);
            sel_mask_reg  <= '0;
            bit_cnt_reg   <= '0;
            shift_reg     <= '0;
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            tvalid_reg    <= 1'b0;
            tdata_reg     <= '0;
            overflow_reg  <= 1'b0;
            truncated_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            spi_clk_d     <= spi_clk;
            cs_active_d   <= cs_active;
            n_reg         <= n_next;
            sel_mask_reg  <= sel_mask_next;
            bit_cnt_reg   <= bit_cnt_next;
            shift_reg     <= shift_next;
            wr_ptr_reg    <= wr_ptr_next;
            rd_ptr_reg    <= rd_ptr_next;
            count_reg     <= count_next;
            tvalid_reg    <= tvalid_next;
            tdata_reg     <= tdata_next;
            overflow_reg  <= overflow_next;
            truncated_reg <= truncated_next;
        end
    end

    assign m_axis_tvalid = tvalid_reg;
    assign m_axis_tdata  = tdata_reg;
    assign overflow      = overflow_reg;
    assign truncated     = truncated_reg;
    assign busy          = (state_reg == ST_CAPTURE);

endmodule

// File: doc/spi_rx_deserializer.md
SPI_RX_DESERIALIZER -- requirements
Module: spi_rx_deserializer

Interface
REQ-001 SHALL have parameter MAX_PACKAGE_SIZE, default 8, meaning max bits per SPI word (2..32).
REQ-002 SHALL have parameter SLAVE_COUNT, default 1, meaning number of chip-selects/MISO lines.
REQ-003 SHALL have parameter AXIS_TDATA_WIDTH, default 32, meaning output stream width (>= MAX_PACKAGE_SIZE).
REQ-004 SHALL have parameter FIFO_DEPTH, default 4, meaning output word buffer entries (power of 2, >= 2).
REQ-005 aclk  input  1  system clock; all logic rising-edge aclk; one clock only.
REQ-006 areset  input  1  reset, synchronous, active-high.
REQ-007 spi_clk  input  1  free-running SPI bit clock, freq << aclk, used as data only.
REQ-008 cpol, cpha  input  1 each  SPI mode bits.
REQ-009 package_size  input  $clog2(MAX_PACKAGE_SIZE+1)  bits per word; 0 or > MAX treated as MAX_PACKAGE_SIZE.
REQ-010 m_spi_cs_o  input  SLAVE_COUNT  chip-select vector as driven to pins, active-low.
REQ-011 m_spi_miso_i  input  SLAVE_COUNT  MISO lines, one per slave.
REQ-012 m_axis_tvalid  output  1; m_axis_tdata  output  AXIS_TDATA_WIDTH; m_axis_tready  input  1  AXI-Stream master of received words.
REQ-013 overflow  output  1  sticky: word dropped, buffer full.
REQ-014 truncated  output  1  sticky: CS deasserted mid-word.
REQ-015 clear_flags  input  1  one-cycle pulse clearing overflow and truncated.
REQ-016 busy  output  1  high in state CAPTURE.

Function
REQ-017 SHALL register spi_clk once into spi_clk_d; sample edge = rising (spi_clk & !spi_clk_d) when cpol^cpha = 0, else falling (!spi_clk & spi_clk_d).
REQ-018 SHALL define cs_active = any bit of m_spi_cs_o low; selected MISO = bit of m_spi_miso_i at lowest index with CS low.
REQ-019 SHALL implement FSM IDLE/CAPTURE: IDLE->CAPTURE on cs_active rising (registered cs_active 0 then 1); CAPTURE->IDLE on cs_active low.
REQ-020 SHALL, on IDLE->CAPTURE, latch effective package_size as N and selected slave index, clear bit counter and shift register; later changes ignored until next entry.
REQ-021 SHALL, in CAPTURE on each sample edge, store selected MISO at bit position = bit counter (LSB-first), increment counter.
REQ-022 SHALL, in the cycle the N-th bit is stored, form word (bits N..AXIS_TDATA_WIDTH-1 zero), push it to the FIFO, reset counter to 0 and stay in CAPTURE for back-to-back words.
REQ-023 SHALL present pushed word on m_axis_tdata with m_axis_tvalid high the cycle after push when FIFO was empty (1-cycle latency).
REQ-024 SHALL pop on m_axis_tvalid & m_axis_tready; tvalid/tdata held stable while tready low.
REQ-025 SHALL, on push while FIFO full, drop the new word, keep stored words, set overflow; simultaneous pop and push at full accepts push.
REQ-026 SHALL, on CS deassert with counter != 0, discard partial word and set truncated; counter = 0 at deassert sets nothing.
REQ-027 SHALL ignore sample edges in IDLE and when cs_active low.
REQ-028 SHALL give set priority over clear_flags when both occur same cycle.
REQ-029 FIFO pointers SHALL wrap modulo FIFO_DEPTH; count width $clog2(FIFO_DEPTH+1).

Reset
REQ-030 areset SHALL, synchronously, force IDLE, empty FIFO, counter 0, m_axis_tvalid 0, m_axis_tdata 0, overflow 0, truncated 0, busy 0, spi_clk_d 0.
REQ-031 areset mid-word SHALL discard partial and buffered words with no flag set.
REQ-032 After reset release with CS already low, SHALL stay IDLE until CS goes high then low.

Verification
REQ-033 Mode 0, N=8, CS0 low, MISO bits LSB-first of 0xA5 -> one beat tdata=0x000000A5 one cycle after 8th rising edge, busy high during capture.
REQ-034 Mode 3 (cpol=1,cpha=1), N=4, MISO pattern 1,0,1,1 on falling... rising edges -> tdata=0xD; Mode 1 same pattern sampled on falling edges -> tdata=0xD.
REQ-035 tready=0, five 8-bit words 0x01..0x05 -> FIFO holds 0x01..0x04, overflow=1; tready=1 -> beats 0x01,0x02,0x03,0x04 in order, then tvalid=0.
REQ-036 CS deasserted after 3 of 8 bits -> no beat, truncated=1; clear_flags pulse -> truncated=0.
REQ-037 SLAVE_COUNT=2, cs=2'b01, MISO[1] drives 0x3C, MISO[0] drives 0xFF -> tdata=0x3C.
REQ-038 areset asserted after 5 of 8 bits with one word buffered -> tvalid=0 next cycle, no flags, next full word delivered correctly.
